// File: rtl/keycode_stream_pio.sv
// keycode_stream_pio: Avalon-MM output PIO with a DEPTH-entry FIFO.
// CPU writes to DATA drive the legacy level output out_port and are also
// queued; the queue drains to hardware consumers over a valid/ready stream.
//
// Stream handshake: out_valid is asserted whenever the FIFO holds an entry
// and stream_en is set, and it never depends on out_ready. out_data is the
// head entry and is meaningful only while out_valid is high. A transfer (pop)
// happens on every rising clk edge where out_valid & out_ready are both high;
// the next head appears in the cycle after that edge.
module keycode_stream_pio #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;

  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  stream_en;
  logic                  irq_en;

  logic                  wr_en;
  logic                  push;
  logic                  pop;
  logic                  push_accept;
  logic                  flush;
  logic                  empty;
  logic                  full;
  logic [DATA_WIDTH-1:0] data_in;

  // Upper writedata bits are intentionally ignored when DATA_WIDTH < 32.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  assign wr_en   = chipselect & ~write_n;
  assign data_in = writedata[DATA_WIDTH-1:0];
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));

  assign push  = wr_en & (address == ADDR_DATA);
  assign flush = wr_en & (address == ADDR_STATUS) & writedata[0];
  assign pop   = out_valid & out_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_accept = push & (~full | pop);

  assign out_valid = ~empty & stream_en;
  assign out_data  = mem[rd_ptr];
  assign out_port  = data_reg;
  assign irq       = irq_en & (empty | overflow);

  // Data register, control bits and sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg  <= RESET_VALUE;
      overflow  <= 1'b0;
      stream_en <= 1'b1;
      irq_en    <= 1'b0;
    end else begin
      if (push) begin
        data_reg <= data_in;
      end
      if (push & full & ~pop) begin
        overflow <= 1'b1;
      end else if (wr_en && address == ADDR_STATUS && writedata[2]) begin
        overflow <= 1'b0;
      end
      if (wr_en && address == ADDR_CONTROL) begin
        stream_en <= writedata[0];
        irq_en    <= writedata[1];
      end
    end
  end

  // FIFO pointers and occupancy; flush overrides a coincident pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_accept) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Register read mux, purely combinational with no side effects.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[DATA_WIDTH-1:0] = data_reg;
      ADDR_STATUS: begin
        readdata[0]    = empty;
        readdata[1]    = full;
        readdata[2]    = overflow;
        readdata[15:8] = 8'(count);
      end
      ADDR_CONTROL: begin
        readdata[0] = stream_en;
        readdata[1] = irq_en;
      end
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_keycode_stream_pio.sv
// Bench for keycode_stream_pio: a queue-based reference model tracks the
// FIFO, data register, overflow and control bits from CPU-visible behaviour.
module tb_keycode_stream_pio;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam logic [DW-1:0] RV = 16'h00AA;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [DW-1:0] out_port;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          irq;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_data;
  logic          m_ovf;
  logic          m_sen;
  logic          m_ien;
  logic [DW-1:0] last_pop;
  int            pop_cnt;

  keycode_stream_pio #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_VALUE(RV)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .irq(irq)
  );

  // Clock and reset
  always #5 clk = ~clk;

  function automatic logic m_valid();
    return (exp_q.size() != 0) && m_sen;
  endfunction

  function automatic logic m_irq();
    return m_ien && ((exp_q.size() == 0) || m_ovf);
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[0] = (exp_q.size() == 0);
    s[1] = (exp_q.size() == DEPTH);
    s[2] = m_ovf;
    s[15:8] = 8'(exp_q.size());
    return s;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_data  = RV;
    m_ovf   = 1'b0;
    m_sen   = 1'b1;
    m_ien   = 1'b0;
    pop_cnt = 0;
  endtask

  // Advance one clock; the model consumes the inputs that the edge sampled.
  task automatic tick();
    logic wr, pop, was_full;
    @(posedge clk);
    if (reset_n) begin
      wr       = chipselect && !write_n;
      pop      = m_valid() && out_ready;
      was_full = (exp_q.size() == DEPTH);
      if (pop) begin
        last_pop = exp_q.pop_front();
        pop_cnt++;
      end
      if (wr && address == 2'd0) begin
        m_data = writedata[DW-1:0];
        if (!was_full || pop) exp_q.push_back(writedata[DW-1:0]);
        else m_ovf = 1'b1;
      end
      if (wr && address == 2'd1) begin
        if (writedata[0]) exp_q.delete();
        if (writedata[2]) m_ovf = 1'b0;
      end
      if (wr && address == 2'd2) begin
        m_sen = writedata[0];
        m_ien = writedata[1];
      end
    end
    #1;
  endtask

  // Driver tasks
  task automatic drive_idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick();
    drive_idle();
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [31:0] v);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    v = readdata;
    drive_idle();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    total++; if (out_port !== RV) begin bad++; $display("FAIL reset_out_port got=%h exp=%h", out_port, RV); end
    cpu_read(2'd1, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL reset_status got=%h exp=%h", v, 32'h1); end
    cpu_read(2'd2, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL reset_control got=%h exp=%h", v, 32'h1); end
    total++; if (out_valid !== 1'b0 || irq !== 1'b0) begin bad++; $display("FAIL reset_valid_irq got=%b%b exp=00", out_valid, irq); end
    cpu_write(2'd0, 32'hDEAD_001A);
    total++; if (out_port !== 16'h001A) begin bad++; $display("FAIL legacy_out_port got=%h exp=%h", out_port, 16'h001A); end
    cpu_read(2'd0, v);
    total++; if (v !== 32'h0000_001A) begin bad++; $display("FAIL data_readback got=%h exp=%h", v, 32'h1A); end
    cpu_read(2'd3, v);
    total++; if (v !== 32'h0) begin bad++; $display("FAIL addr3_read got=%h exp=0", v); end
  endtask

  task automatic test_ordered_drain();
    logic [31:0] v;
    logic [DW-1:0] exp_vals[3];
    exp_vals[0] = 16'h04; exp_vals[1] = 16'h05; exp_vals[2] = 16'h06;
    out_ready = 1'b0;
    cpu_write(2'd1, 32'h1);
    for (int i = 0; i < 3; i++) cpu_write(2'd0, {16'h0, exp_vals[i]});
    cpu_read(2'd1, v);
    total++; if (v !== 32'h0300) begin bad++; $display("FAIL drain_count got=%h exp=%h", v, 32'h0300); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== exp_vals[i]) begin
        bad++; $display("FAIL drain_data[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, exp_vals[i]);
      end
      tick();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_end_valid got=%b exp=0", out_valid); end
    cpu_read(2'd1, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL drain_end_status got=%h exp=1", v); end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) cpu_write(2'd0, 32'(i));
    cpu_read(2'd1, v);
    total++; if (v !== 32'h0806) begin bad++; $display("FAIL ovf_status got=%h exp=%h", v, 32'h0806); end
    total++; if (out_port !== 16'h9) begin bad++; $display("FAIL ovf_out_port got=%h exp=9", out_port); end
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== DW'(i)) begin
        bad++; $display("FAIL ovf_drain[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, DW'(i));
      end
      tick();
    end
    out_ready = 1'b0;
    cpu_write(2'd1, 32'h4);
    cpu_read(2'd1, v);
    total++; if (v !== 32'h1 || v !== m_status()) begin bad++; $display("FAIL ovf_clear got=%h exp=%h", v, 32'h1); end
  endtask

  task automatic test_full_pop();
    logic [31:0] v;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) cpu_write(2'd0, 32'($urandom_range(0, 16'hFFFF)));
    cpu_read(2'd1, v);
    total++; if (v !== 32'h0802) begin bad++; $display("FAIL full_status got=%h exp=%h", v, 32'h0802); end
    out_ready = 1'b1;
    cpu_write(2'd0, 32'h0A);
    out_ready = 1'b0;
    cpu_read(2'd1, v);
    total++; if (v !== 32'h0802 || v !== m_status()) begin bad++; $display("FAIL full_pop_status got=%h exp=%h", v, 32'h0802); end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
        bad++; $display("FAIL full_pop_drain[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, exp_q[0]);
      end
      tick();
    end
    out_ready = 1'b0;
    total++; if (last_pop !== 16'h0A || out_valid !== 1'b0) begin bad++; $display("FAIL full_pop_last got=%h/%b exp=000a/0", last_pop, out_valid); end
  endtask

  task automatic test_wrap_irq();
    logic [31:0] v;
    int pushed;
    int cycles;
    cpu_write(2'd2, 32'h3);
    pushed  = 0;
    cycles  = 0;
    pop_cnt = 0;
    while ((pushed < 20 || exp_q.size() != 0) && cycles < 400) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (pushed < 20 && exp_q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
        address    = 2'd0;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = {16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF))};
        pushed++;
      end
      total++; if (out_valid !== m_valid() || irq !== m_irq() || (m_valid() && out_data !== exp_q[0])) begin
        bad++; $display("FAIL wrap_cycle[%0d] got=%b/%b/%h exp=%b/%b/%h", cycles, out_valid, irq, out_data,
                        m_valid(), m_irq(), (exp_q.size() != 0) ? exp_q[0] : 16'h0);
      end
      tick();
      drive_idle();
      cycles++;
    end
    total++; if (cycles >= 400 || pop_cnt != 20) begin bad++; $display("FAIL wrap_complete got=%0d pops exp=20 (cycles=%0d)", pop_cnt, cycles); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_empty got=%b exp=1", irq); end
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) cpu_write(2'd0, 32'($urandom_range(0, 16'hFFFF)));
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_nonempty got=%b exp=0", irq); end
    cpu_write(2'd1, 32'h1);
    cpu_read(2'd1, v);
    total++; if (v !== 32'h1 || irq !== 1'b1) begin bad++; $display("FAIL flush got=%h/%b exp=00000001/1", v, irq); end
  endtask

  task automatic test_stream_en_reset();
    logic [31:0] v;
    cpu_write(2'd2, 32'h1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) cpu_write(2'd0, 32'($urandom_range(0, 16'hFFFF)));
    cpu_write(2'd2, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_off_valid[%0d] got=%b exp=0", i, out_valid); end
      tick();
    end
    cpu_read(2'd1, v);
    total++; if (v !== 32'h0300) begin bad++; $display("FAIL stream_off_count got=%h exp=%h", v, 32'h0300); end
    cpu_write(2'd2, 32'h1);
    total++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin bad++; $display("FAIL resume_head got=%b/%h exp=1/%h", out_valid, out_data, exp_q[0]); end
    tick();
    total++; if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin bad++; $display("FAIL resume_second got=%b/%h exp=1/%h", out_valid, out_data, exp_q[0]); end
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    total++; if (out_valid !== 1'b0 || irq !== 1'b0) begin bad++; $display("FAIL async_reset_valid got=%b/%b exp=0/0", out_valid, irq); end
    total++; if (out_port !== RV) begin bad++; $display("FAIL async_reset_port got=%h exp=%h", out_port, RV); end
    cpu_read(2'd1, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL async_reset_status got=%h exp=1", v); end
    cpu_read(2'd2, v);
    total++; if (v !== 32'h1) begin bad++; $display("FAIL async_reset_control got=%h exp=1", v); end
    out_ready = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0 || out_port !== RV) begin bad++; $display("FAIL post_reset got=%b/%h exp=0/%h", out_valid, out_port, RV); end
  endtask

  initial begin
    reset_n   = 1'b0;
    out_ready = 1'b0;
    drive_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    test_reset();
    test_ordered_drain();
    test_overflow();
    test_full_pop();
    test_wrap_irq();
    test_stream_en_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keycode_stream_pio.md
# keycode_stream_pio

Parametrised Avalon-MM output PIO with an internal FIFO. The CPU writes keycodes (or any DATA_WIDTH value) over the Avalon-MM slave. Each written value drives a legacy level output, `out_port`, and is also queued into a DEPTH-entry FIFO that drains to hardware consumers over a valid/ready stream. The block sits between the Nios II data master and keyboard-driven game/display logic, so that back-to-back key events are not lost between consumer cycles.

## Interface
Parameters:
- DATA_WIDTH, 16, width of data register, FIFO entries and stream data (1..32)
- DEPTH, 8, FIFO entries; power of two, 2..128
- RESET_VALUE, 0, reset value of the `out_port` data register

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- address  in  2  Avalon word address
- chipselect  in  1  Avalon select
- write_n  in  1  Avalon write strobe, active-low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data; combinational, zero wait states, no read side effects
- out_port  out  DATA_WIDTH  last value written to DATA (legacy level output)
- out_data  out  DATA_WIDTH  FIFO head
- out_valid  out  1  FIFO non-empty and stream enabled
- out_ready  in  1  consumer accepts head
- irq  out  1  level interrupt

## Operation
- The block performs a write when `chipselect & ~write_n`. Unused `writedata` bits are ignored. Unused `readdata` bits read 0.
- Address 0, DATA:
  - Write loads `writedata[DATA_WIDTH-1:0]` into the data register.
  - The same write pushes that value into the FIFO.
  - Read returns the data register.
- Address 1, STATUS (read):
  - [0] empty
  - [1] full
  - [2] overflow (sticky)
  - [15:8] count, zero-extended
- STATUS write:
  - Bit 0 = 1 flushes the FIFO (count 0).
  - Bit 2 = 1 clears overflow.
  - Other bits are ignored.
- Address 2, CONTROL (read/write):
  - [0] stream_en
  - [1] irq_en
- Address 3: reads 0; writes are ignored.
- Pop occurs when `out_valid & out_ready`. `out_valid = ~empty & stream_en`. `out_data` = head entry, valid only while `out_valid` = 1.
- Push to a full FIFO with no pop in the same cycle:
  - The value is dropped and overflow is set.
  - The data register still updates.
- Push to a full FIFO with a pop in the same cycle: accepted; count unchanged.
- Push and pop in the same cycle when not full: count unchanged.
- Flush coincident with a pop: flush wins; count 0.
- Flush does not alter the data register or overflow.
- `irq = irq_en & (empty | overflow)`. The CPU refills on empty and services overflow by clearing it.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits and saturates neither way, because push/pop rules prevent over/underflow.

## Timing
Reset values (asynchronous reset):
- data register / `out_port` = RESET_VALUE
- pointers 0, count 0
- overflow 0
- stream_en 1, irq_en 0
- `out_valid` 0, `irq` 0

Latencies and ordering:
- `out_port` and STATUS reflect a write on the clock edge that samples it. Registers read back the new value in the next cycle.
- Write to DATA on an empty FIFO → `out_valid` = 1 in the following cycle, with `out_data` = written value (latency 1).
- The pop edge advances the head. The new `out_data` is visible in the cycle after that edge. The consumer may hold `out_ready` high for one pop per cycle.
- The stream is FIFO-ordered. No entry is duplicated or skipped across pointer wrap.
- Clearing stream_en mid-stream:
  - `out_valid` drops in the next cycle.
  - FIFO contents are retained and resume in order when stream_en returns to 1.
- `readdata` is purely combinational on `address` and the current register state.
- Reset asserted mid-operation empties the FIFO immediately. `out_valid` and `irq` fall asynchronously.

## Test plan
- **Reset and legacy output:** reset with RESET_VALUE = 16'h00AA → `out_port` = 00AA and STATUS = 0x0001. Write DATA = 0x001A → `out_port` = 001A and DATA reads 0x0000001A.
- **Ordered drain:** `out_ready` = 0; write 0x04, 0x05, 0x06 → STATUS count = 3. Then hold `out_ready` = 1 → `out_data` = 04, 05, 06 on consecutive cycles, then `out_valid` = 0 and STATUS = 0x0001.
- **Overflow:** DEPTH = 8, `out_ready` = 0; write 9 values 1..9 →
  - STATUS = 0x0806 (full, overflow, count 8) and `out_port` = 9.
  - Draining yields 1..8.
  - Write STATUS = 0x4 → overflow 0.
- **Full with simultaneous pop:** with the FIFO full, write 0x0A in the same cycle as a pop → count stays 8 and overflow stays 0; 0x0A emerges last.
- **Wrap and interrupt:**
  - CONTROL = 0x3; push/pop 20 values through DEPTH 8 → no loss or reordering.
  - `irq` = 1 whenever empty.
  - Write STATUS = 0x1 while holding 5 entries → count 0, `irq` = 1.
- **Stream enable and reset:**
  - Load 3 entries; CONTROL = 0x0 → `out_valid` = 0 for 10 cycles with `out_ready` = 1, count stays 3.
  - CONTROL = 0x1 → entries resume in order.
  - Assert reset_n mid-drain → `out_valid` = 0 immediately and all registers return to reset values.
